rr_arbiter4: RTL and testbench

- Round-robin arbiter that shares one 4-way resource among 4 requesters.
- Produces a registered one-hot grant, the matching 2-bit index and a busy flag.
- The 2-bit index is intended to drive the existing 2-to-4 decoder select path.
- Sits between the requesting units and the shared datapath; a hold-time limit prevents any requester from starving the others.

---
 rtl/rr_arbiter4_if.sv | 29 ++
 rtl/rr_arbiter4.sv | 116 +++++++++++
 tb/tb_rr_arbiter4.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rr_arbiter4_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter4_if : request/grant bundle between requesters and rr_arbiter4
// Revision: 1.0
// ---------------------------------------------------------------------------
interface rr_arbiter4_if;
  logic       en;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;

  modport master (
    output en,
    output req,
    input  grant,
    input  grant_idx,
    input  busy
  );

  modport slave (
    input  en,
    input  req,
    output grant,
    output grant_idx,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter4 : 4-way round-robin arbiter with registered one-hot grant
//               and a hold-time limit against starvation
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter4_if.slave bus
);

  localparam logic [0:0]       ST_IDLE   = 1'b0;
  localparam logic [0:0]       ST_GRANT  = 1'b1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       state_q,     state_d;
  logic [1:0]       ptr_q,       ptr_d;
  logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic [3:0]       grant_q,     grant_d;
  logic [1:0]       grant_idx_q, grant_idx_d;

  logic [3:0]       eligible;
  logic             timeout;
  logic             terminate;
  logic [2:0]       pick_idle;
  logic [2:0]       pick_next;

  // Returns {found, index} of the first set bit of vec searching start, start+1, ... mod 4.
  function automatic logic [2:0] pick_first(input logic [3:0] vec, input logic [1:0] start);
    logic [7:0] dbl;
    logic [1:0] off;
    logic       found;
    dbl   = {vec, vec} >> start;
    off   = 2'd0;
    found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (dbl[i]) begin
        off   = i[1:0];
        found = 1'b1;
      end
    end
    return {found, 2'(start + off)};
  endfunction

  always_comb begin
    eligible  = bus.req & ~grant_q;
    timeout   = (hold_cnt_q == HOLD_LAST) && (eligible != 4'b0000);
    terminate = !bus.req[grant_idx_q] || timeout;
    pick_idle = pick_first(bus.req, ptr_q);
    pick_next = pick_first(eligible, 2'(grant_idx_q + 2'd1));

    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.en && pick_idle[2]) begin
          state_d     = ST_GRANT;
          grant_idx_d = pick_idle[1:0];
          grant_d     = 4'(1) << pick_idle[1:0];
          hold_cnt_d  = '0;
        end
      end
      default: begin
        if (!bus.en) begin
          state_d    = ST_IDLE;
          grant_d    = 4'b0000;
          ptr_d      = 2'(grant_idx_q + 2'd1);
          hold_cnt_d = '0;
        end else if (terminate) begin
          ptr_d      = 2'(grant_idx_q + 2'd1);
          hold_cnt_d = '0;
          // Hand over on the same edge so the resource never idles while others wait.
          if (pick_next[2]) begin
            grant_idx_d = pick_next[1:0];
            grant_d     = 4'(1) << pick_next[1:0];
          end else begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
          end
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 2'd0;
      hold_cnt_q  <= '0;
      grant_q     <= 4'b0000;
      grant_idx_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.busy      = |grant_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rr_arbiter4 : table-driven scoreboard bench for rr_arbiter4 (MAX_HOLD=4)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_rr_arbiter4;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] idx;
  } vec_t;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] idx;
    logic       busy;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  rr_arbiter4_if bus();

  rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req_v, $time);
    end
  endtask

  function automatic void add(input logic r, input logic e, input logic [3:0] rq,
                              input logic [3:0] g, input logic [1:0] i);
    vec_t v;
    v.rst_n = r; v.en = e; v.req = rq; v.grant = g; v.idx = i;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic r, input logic e, input logic [3:0] rq,
                      input logic [3:0] g, input logic [1:0] i);
    exp_t x;
    @(negedge clk);
    rst_n   = r;
    bus.en  = e;
    bus.req = rq;
    x.grant = g; x.idx = i; x.busy = |g;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      x = exp_q.pop_front();
      check("grant", 32'(bus.grant), 32'(x.grant));
      check("grant_idx", 32'(bus.grant_idx), 32'(x.idx));
      check("busy", 32'(bus.busy), 32'(x.busy));
    end
    check("inv_onehot0", 32'($onehot0(bus.grant)), 32'd1);
    check("inv_busy_or", 32'(bus.busy), 32'(|bus.grant));
    if (bus.busy)
      check("inv_idx_match", 32'(bus.grant), 32'(4'(1) << bus.grant_idx));
    check("inv_grant_req", 32'(bus.grant & ~rq), 32'd0);
  endtask

  initial begin
    bus.en  = 1'b0;
    bus.req = 4'b0000;

    // Reset, single requester, then verify ptr moved to 3.
    add(0, 0, 4'b0000, 4'b0000, 2'd0);
    add(0, 0, 4'b0000, 4'b0000, 2'd0);
    add(1, 1, 4'b0100, 4'b0100, 2'd2);
    add(1, 1, 4'b0000, 4'b0000, 2'd2);
    add(1, 1, 4'b1001, 4'b1000, 2'd3);
    add(1, 1, 4'b0000, 4'b0000, 2'd3);
    // Back-to-back rotation with each holder releasing after one cycle.
    add(0, 1, 4'b1111, 4'b0000, 2'd0);
    add(1, 1, 4'b1111, 4'b0001, 2'd0);
    add(1, 1, 4'b1110, 4'b0010, 2'd1);
    add(1, 1, 4'b1101, 4'b0100, 2'd2);
    add(1, 1, 4'b1011, 4'b1000, 2'd3);
    add(1, 1, 4'b0111, 4'b0001, 2'd0);
    add(1, 1, 4'b0000, 4'b0000, 2'd0);
    // Timeout alternation between requesters 0 and 1.
    add(0, 1, 4'b0000, 4'b0000, 2'd0);
    for (int k = 0; k < 4; k++) add(1, 1, 4'b0011, 4'b0001, 2'd0);
    for (int k = 0; k < 4; k++) add(1, 1, 4'b0011, 4'b0010, 2'd1);
    for (int k = 0; k < 2; k++) add(1, 1, 4'b0011, 4'b0001, 2'd0);
    add(1, 1, 4'b0000, 4'b0000, 2'd0);

    foreach (vecs[k])
      step(vecs[k].rst_n, vecs[k].en, vecs[k].req, vecs[k].grant, vecs[k].idx);

    // Lone holder never times out (ptr is 1 here, so requester 3 wins).
    repeat (20) step(1, 1, 4'b1000, 4'b1000, 2'd3);
    step(1, 1, 4'b0000, 4'b0000, 2'd3);

    // Disable mid-grant, then resume from the advanced pointer.
    step(1, 1, 4'b0010, 4'b0010, 2'd1);
    step(1, 0, 4'b1111, 4'b0000, 2'd1);
    step(1, 0, 4'b1111, 4'b0000, 2'd1);
    step(1, 1, 4'b1111, 4'b0100, 2'd2);
    step(1, 1, 4'b0000, 4'b0000, 2'd2);

    // Reset in the middle of a grant restarts the pointer at 0.
    step(1, 1, 4'b1000, 4'b1000, 2'd3);
    step(0, 1, 4'b1111, 4'b0000, 2'd0);
    step(1, 1, 4'b1010, 4'b0010, 2'd1);

    // Holder drops on the timeout edge while en falls: result is idle.
    step(1, 1, 4'b0110, 4'b0010, 2'd1);
    step(1, 1, 4'b0110, 4'b0010, 2'd1);
    step(1, 1, 4'b0110, 4'b0010, 2'd1);
    step(1, 0, 4'b0100, 4'b0000, 2'd1);
    step(1, 1, 4'b0000, 4'b0000, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
